// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg : shared types and constants for the loadable instruction memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // MOV R0,R0
  localparam logic [31:0] C_NOP_WORD = 32'hE1A00000;

  typedef logic [1:0] lane_t;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loadable_if.sv
// ---------------------------------------------------------------------------
// imem_loadable_if : fetch port and byte-serial boot-load port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface imem_loadable_if #(
  parameter int ADDR_W = 32
) ();

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              flush;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              fetch_err;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, stall, flush,
    output load_start, load_valid, load_byte, load_last,
    input  fetch_valid, fetch_data, fetch_err,
    input  load_ready, load_done, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, flush,
    input  load_start, load_valid, load_byte, load_last,
    output fetch_valid, fetch_data, fetch_err,
    output load_ready, load_done, busy
  );

endinterface

`default_nettype wire

// File: rtl/imem_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_byte_packer : assembles little-endian bytes into 32-bit words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        last_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        wstrb_o,
  output logic        pad_req_o
);

  lane_t       lane_q;
  logic [31:0] word_q;
  logic [31:0] w_merged;

  always_comb begin
    w_merged = word_q;
    if (valid_i) begin
      w_merged[{lane_q, 3'b000} +: 8] = data_i;
    end
  end

  assign word_o    = w_merged;
  assign wstrb_o   = valid_i && (lane_q == 2'd3);
  assign pad_req_o = valid_i && last_i && (lane_q != 2'd3);

  // Word register returns to zero after each full word so a padded word has clean upper bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (valid_i) begin
      if (lane_q == 2'd3) begin
        lane_q <= '0;
        word_q <= '0;
      end else begin
        lane_q <= lane_q + 2'd1;
        word_q <= w_merged;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable : registered-read instruction memory with byte-serial loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_loadable_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  C_DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_DEPTH_ADDR = ADDR_W'(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             fv_q, fv_d;
  logic [31:0]      fd_q, fd_d;
  logic             fe_q, fe_d;

  logic        w_load_ready;
  logic        w_pk_valid;
  logic        w_pk_clear;
  logic [31:0] w_pk_word;
  logic        w_pk_wstrb;
  logic        w_pk_pad;
  logic        w_mem_we;
  logic        w_bad_addr;

  assign w_cnt_inc    = cnt_q + CNT_W'(1);
  assign w_load_ready = (state_q == LOAD) && (cnt_q < C_DEPTH_CNT);
  assign w_pk_valid   = bus.load_valid && w_load_ready;
  assign w_bad_addr   = (|bus.fetch_addr[1:0]) || ((bus.fetch_addr >> 2) >= C_DEPTH_ADDR);

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (bus.load_byte),
    .valid_i   (w_pk_valid),
    .last_i    (bus.load_last),
    .clear_i   (w_pk_clear),
    .word_o    (w_pk_word),
    .wstrb_o   (w_pk_wstrb),
    .pad_req_o (w_pk_pad)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_mem_we   = 1'b0;
    w_pk_clear = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.load_start) begin
          state_d    = LOAD;
          cnt_d      = '0;
          w_pk_clear = 1'b1;
        end
      end
      LOAD: begin
        if (w_pk_wstrb) begin
          w_mem_we = 1'b1;
          cnt_d    = w_cnt_inc;
          if (bus.load_last || (w_cnt_inc == C_DEPTH_CNT)) begin
            state_d = DONE;
          end
        end else if (w_pk_pad) begin
          state_d = PAD;
        end
      end
      PAD: begin
        // Packer already holds the partial word with zeroed upper bytes
        w_mem_we   = 1'b1;
        cnt_d      = w_cnt_inc;
        w_pk_clear = 1'b1;
        state_d    = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Fetch priority: flush > stall > load_start > fetch_req
  always_comb begin
    fv_d = fv_q;
    fd_d = fd_q;
    fe_d = fe_q;
    if (state_q == RUN) begin
      if (bus.flush) begin
        fv_d = 1'b0;
        fd_d = NOP_WORD;
        fe_d = 1'b0;
      end else if (bus.stall) begin
        fv_d = fv_q;
      end else if (bus.load_start) begin
        fv_d = 1'b0;
        fe_d = 1'b0;
      end else if (bus.fetch_req) begin
        fv_d = 1'b1;
        if (w_bad_addr) begin
          fd_d = NOP_WORD;
          fe_d = 1'b1;
        end else begin
          fd_d = mem[bus.fetch_addr[IDX_W+1:2]];
          fe_d = 1'b0;
        end
      end else begin
        fv_d = 1'b0;
        fe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fd_q    <= NOP_WORD;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fd_q    <= fd_d;
      fe_q    <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[cnt_q[IDX_W-1:0]] <= w_pk_word;
    end
  end

  assign bus.fetch_valid = fv_q;
  assign bus.fetch_data  = fd_q;
  assign bus.fetch_err   = fe_q;
  assign bus.load_ready  = w_load_ready;
  assign bus.load_done   = (state_q == DONE);
  assign bus.busy        = (state_q != RUN);

endmodule

`default_nettype wire

// File: tb/tb_imem_loadable.sv
// ---------------------------------------------------------------------------
// tb_imem_loadable : directed self-checking bench for imem_loadable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  imem_loadable_if #(.ADDR_W(32)) bus ();

  imem_loadable #(.DEPTH(64), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_load();
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    bus.load_last  = last;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    @(posedge clk); #1;
    bus.fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== NOP) begin n_err++; $display("FAIL rst_data: got %h want %h", bus.fetch_data, NOP); end
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.fetch_err); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.load_ready); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.load_done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_two_words();
    start_load();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ld_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready: got %b want 1", bus.load_ready); end
    send_byte(8'h14, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hA0, 1'b0); send_byte(8'hE3, 1'b0);
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL ld_done_early: got %b want 0", bus.load_done); end
    send_byte(8'h01, 1'b0); send_byte(8'h1A, 1'b0); send_byte(8'hA0, 1'b0); send_byte(8'hE3, 1'b1);
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL ld_done: got %b want 1", bus.load_done); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL ld_ready_done: got %b want 0", bus.load_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL ld_done_pulse: got %b want 0", bus.load_done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ld_busy_end: got %b want 0", bus.busy); end
    fetch(32'h0);
    n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL f0_valid: got %b want 1", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== 32'hE3A00014) begin n_err++; $display("FAIL f0_data: got %h want e3a00014", bus.fetch_data); end
    fetch(32'h4);
    n_cmp++; if (bus.fetch_data !== 32'hE3A01A01) begin n_err++; $display("FAIL f4_data: got %h want e3a01a01", bus.fetch_data); end
  endtask

  task automatic test_pad();
    start_load();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'hAB, 1'b1);
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready: got %b want 0", bus.load_ready); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL pad_done_early: got %b want 0", bus.load_done); end
    @(posedge clk); #1;
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL pad_done: got %b want 1", bus.load_done); end
    @(posedge clk); #1;
    fetch(32'h4);
    n_cmp++; if (bus.fetch_data !== 32'h000000AB) begin n_err++; $display("FAIL pad_word: got %h want 000000ab", bus.fetch_data); end
    fetch(32'h0);
    n_cmp++; if (bus.fetch_data !== 32'h44332211) begin n_err++; $display("FAIL pad_w0: got %h want 44332211", bus.fetch_data); end
  endtask

  task automatic test_fetch_err();
    fetch(32'h2);
    n_cmp++; if (bus.fetch_err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", bus.fetch_err); end
    n_cmp++; if (bus.fetch_data !== NOP) begin n_err++; $display("FAIL mis_data: got %h want %h", bus.fetch_data, NOP); end
    n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b want 1", bus.fetch_valid); end
    fetch(32'h100);
    n_cmp++; if (bus.fetch_err !== 1'b1) begin n_err++; $display("FAIL oob_err: got %b want 1", bus.fetch_err); end
    n_cmp++; if (bus.fetch_data !== NOP) begin n_err++; $display("FAIL oob_data: got %h want %h", bus.fetch_data, NOP); end
    fetch(32'hFC);
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_err++; $display("FAIL last_idx_err: got %b want 0", bus.fetch_err); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h8; addrs[2] = 32'h100;
    fetch(32'h4);
    bus.stall     = 1'b1;
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_addr = addrs[i];
      @(posedge clk); #1;
      n_cmp++; if (bus.fetch_data !== 32'h000000AB) begin n_err++; $display("FAIL stall_data[%0d]: got %h want 000000ab", i, bus.fetch_data); end
      n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_err !== 1'b0) begin n_err++; $display("FAIL stall_flags[%0d]: got v=%b e=%b want v=1 e=0", i, bus.fetch_valid, bus.fetch_err); end
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== NOP) begin n_err++; $display("FAIL flush_data: got %h want %h", bus.fetch_data, NOP); end
    bus.flush     = 1'b0;
    bus.stall     = 1'b0;
    bus.fetch_req = 1'b0;
  endtask

  task automatic test_no_req();
    fetch(32'h0);
    @(posedge clk); #1;
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_data !== 32'h44332211) begin n_err++; $display("FAIL idle_hold: got %h want 44332211", bus.fetch_data); end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rml_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rml_done: got %b want 0", bus.load_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL rml_ready: got %b want 0", bus.load_ready); end
    fetch(32'h0);
    n_cmp++; if (bus.fetch_data !== 32'h04030201) begin n_err++; $display("FAIL rml_w0: got %h want 04030201", bus.fetch_data); end
    fetch(32'h4);
    n_cmp++; if (bus.fetch_data !== 32'h000000AB) begin n_err++; $display("FAIL rml_w1: got %h want 000000ab", bus.fetch_data); end
  endtask

  task automatic test_full_depth();
    start_load();
    for (int k = 0; k < 256; k++) send_byte(8'(k), 1'b0);
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", bus.load_done); end
    n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.load_ready); end
    @(posedge clk); #1;
    fetch(32'hFC);
    n_cmp++; if (bus.fetch_data !== 32'hFFFEFDFC) begin n_err++; $display("FAIL full_w63: got %h want fffefdfc", bus.fetch_data); end
    fetch(32'h0);
    n_cmp++; if (bus.fetch_data !== 32'h03020100) begin n_err++; $display("FAIL full_w0: got %h want 03020100", bus.fetch_data); end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    bus.load_last  = 1'b0;
    test_reset();
    test_load_two_words();
    test_pad();
    test_fetch_err();
    test_stall_flush();
    test_no_req();
    test_reset_mid_load();
    test_full_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the ARM pipeline's IF stage. Replaces a hard-coded, combinational-read program store with a registered-read fetch port that supports stall and flush, plus a byte-serial boot-load port. Programs can be written at run time without re-elaborating the design. It sits between the PC register and the IF/ID pipeline register; the boot loader drives the load port.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit instruction words; power of two, at least 4.
- ADDR_W, 32, width of the byte address from the PC.
- NOP_WORD, 32'hE1A00000, word returned on flush, error or reset (MOV R0,R0).

Ports:
- clk, in, 1, single clock; all state is updated on the rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- fetch_req, in, 1, fetch request from IF.
- fetch_addr, in, ADDR_W, byte address (PC).
- stall, in, 1, holds the fetch outputs.
- flush, in, 1, kills the fetched instruction.
- fetch_valid, out, 1, fetch_data holds a fetched word.
- fetch_data, out, 32, instruction word.
- fetch_err, out, 1, the fetch was misaligned or out of range.
- load_start, in, 1, request to enter load mode.
- load_valid, in, 1, load_byte is valid this cycle.
- load_byte, in, 8, program byte; bytes arrive little-endian within each word.
- load_last, in, 1, marks the final byte of the program.
- load_ready, out, 1, the block accepts a byte this cycle.
- load_done, out, 1, one-cycle pulse when loading completes.
- busy, out, 1, high while not in RUN.

## Operation
States:
- RUN: fetch port active.
- LOAD: bytes are accepted.
- PAD: flushes a partial final word.
- DONE: pulses load_done.

Reset:
- State goes to RUN.
- Outputs: fetch_valid=0, fetch_data=NOP_WORD, fetch_err=0, load_ready=0, load_done=0, busy=0.
- Byte lane and word counter are cleared.
- Memory contents are not reset.

Fetch in RUN, with priority flush > stall > fetch_req:
- flush: on the next edge, fetch_valid=0, fetch_data=NOP_WORD, fetch_err=0.
- stall (no flush): all fetch outputs are held unchanged.
- fetch_req, with word index = fetch_addr[ADDR_W-1:2]:
  - If fetch_addr[1:0]!=0 or index>=DEPTH: fetch_data=NOP_WORD, fetch_err=1, fetch_valid=1.
  - Otherwise: fetch_data=mem[index], fetch_err=0, fetch_valid=1.
- No request: fetch_valid=0 and fetch_data is held.

load_start:
- Sampled only in RUN; it overrides fetch_req in the same cycle.
- Transition RUN->LOAD clears fetch_valid, word_cnt and the byte lane.

LOAD:
- load_ready=1.
- Each accepted byte (load_valid) goes into lane 0..3 of the assembly register.
- When lane 3 is accepted, the word is written to mem[word_cnt] at that edge, word_cnt increments and the lane returns to 0.
- If load_last is on lane 3, or a write brings word_cnt to DEPTH, go to DONE.
- If load_last is on lane 0..2, go to PAD.

PAD:
- load_ready=0.
- Unfilled upper bytes are zero; the word is written to mem[word_cnt]; go to DONE.

DONE:
- load_done=1 for one cycle, then go to RUN.

Boundary cases:
- Bytes offered after word DEPTH-1 has been written are not accepted (load_ready=0).
- load_start asserted in LOAD, PAD or DONE is ignored.
- Reset mid-load: words already written remain; the partial word is discarded.

## Timing
- Fetch latency is 1 cycle: the request and address are sampled at edge N, and fetch_data/fetch_valid/fetch_err are valid after edge N.
- Back-to-back fetches give one word per cycle.
- A load accepts at most one byte per cycle: a full word needs 4 cycles and the write lands on the 4th edge.
- A word written in LOAD is readable by the first fetch issued in RUN after DONE.
- load_done rises exactly one cycle after the final memory write.
- busy is asserted from the cycle after load_start is accepted until RUN is re-entered.

## Structure
- imem_pkg holds:
  - the state enum (RUN, LOAD, PAD, DONE);
  - the NOP_WORD default constant;
  - the lane index type (2 bits);
  - a word-index width function, clog2(DEPTH).
- Sub-module imem_byte_packer:
  - Inputs: byte, valid, last and clear.
  - Outputs: the assembled 32-bit word, a write strobe and the pad request.
  - The FSM and memory array stay in the top level.

## Test plan
- Reset release, then fetch 0x0 for a program loaded with 0xE3A00014 -> after 1 cycle, fetch_valid=1 and fetch_data=0xE3A00014.
- Load bytes 14 00 A0 E3 01 1A A0 E3 with load_last on the 8th byte -> mem[0]=0xE3A00014, mem[1]=0xE3A01A01, load_done pulses one cycle after the second write.
- Load 5 bytes with load_last on the 5th, byte 5 = 0xAB -> PAD writes mem[1]=0x000000AB.
- Fetch 0x2 and fetch 0x100 (DEPTH=64) -> fetch_err=1, fetch_data=0xE1A00000.
- Fetch 0x4, then stall for 3 cycles while the address changes -> outputs stay at mem[1]. Then flush together with stall -> fetch_valid=0 on the next cycle.
- Assert rst_n=0 after 6 load bytes -> mem[0] keeps the loaded word, mem[1] is unchanged, state returns to RUN and load_done stays 0.
